// File: rtl/count_seq_checker.sv
// Checks that an upstream modulo counter advances by one on every enabled sample. It reports lock, errors and wraps, and raises a sticky fault.
// Optional macro CNT_CHK_HOLD_OK_EN treats a repeated value as a legal hold and adds the hold_pulse output.
module count_seq_checker #(
   parameter int WIDTH      = 4,
   parameter int MAX_COUNT  = 15,
   parameter int ERR_LIMIT  = 3,
   parameter int ERR_CNT_W  = 8,
   parameter int WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      count_in,
   input  logic                  enable,
   input  logic                  clear_fault,
   output logic                  locked,
   output logic                  fault,
   output logic                  err_pulse,
   output logic                  wrap_pulse,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WRAP_CNT_W-1:0] wrap_count
`ifdef CNT_CHK_HOLD_OK_EN
   ,
   output logic                  hold_pulse
`endif
);

   localparam int CE_W = $clog2(ERR_LIMIT + 1);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
   localparam logic [CE_W-1:0]  LIM_M1 = CE_W'(ERR_LIMIT - 1);

   typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;

   state_t           state;
   logic [WIDTH-1:0] prev;
   logic [1:0]       good_run;
   logic [CE_W-1:0]  consec_err;
   logic [WIDTH-1:0] expected;
   logic             is_match;
   logic             is_hold;

   // An out-of-range value is never legal, even if it happens to equal expected or prev.
   always_comb begin
      expected = (prev == MAX_V) ? '0 : prev + 1'b1;
      is_match = (count_in <= MAX_V) && (count_in == expected);
`ifdef CNT_CHK_HOLD_OK_EN
      is_hold  = !is_match && (count_in <= MAX_V) && (count_in == prev);
`else
      is_hold  = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         prev       <= '0;
         good_run   <= '0;
         consec_err <= '0;
         locked     <= 1'b0;
         fault      <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         err_count  <= '0;
         wrap_count <= '0;
`ifdef CNT_CHK_HOLD_OK_EN
         hold_pulse <= 1'b0;
`endif
      end else begin
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
`ifdef CNT_CHK_HOLD_OK_EN
         hold_pulse <= 1'b0;
`endif
         if (enable) begin
            prev <= count_in;
            case (state)
               IDLE: begin
                  state    <= SYNC;
                  good_run <= '0;
               end
               SYNC: begin
                  if (is_match) begin
                     if (good_run == 2'd1) begin
                        state    <= TRACK;
                        locked   <= 1'b1;
                        good_run <= '0;
                     end else begin
                        good_run <= good_run + 2'd1;
                     end
                  end else if (!is_hold) begin
                     good_run <= '0;
                  end
               end
               TRACK: begin
                  if (is_match) begin
                     consec_err <= '0;
                     if (prev == MAX_V) begin
                        wrap_pulse <= 1'b1;
                        if (wrap_count != '1) wrap_count <= wrap_count + 1'b1;
                     end
                  end else if (is_hold) begin
`ifdef CNT_CHK_HOLD_OK_EN
                     hold_pulse <= 1'b1;
`endif
                  end else begin
                     err_pulse  <= 1'b1;
                     consec_err <= consec_err + 1'b1;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                     if (consec_err >= LIM_M1) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                     end
                  end
               end
               FAULT: begin
                  if (clear_fault) begin
                     state      <= IDLE;
                     fault      <= 1'b0;
                     consec_err <= '0;
                     good_run   <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
